core_mgmt_initiator: RTL and testbench

//  Initiator side of the core-management register port: turns halt/release requests from the boot core

---
 rtl/core_mgmt_initiator_pkg.sv | 44 ++++
 rtl/core_mgmt_initiator_if.sv | 23 ++
 rtl/core_mgmt_initiator.sv | 186 ++++++++++++++++++
 tb/tb_core_mgmt_initiator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_mgmt_initiator_pkg.sv
// Core-management types shared by the initiator and the core-management slave:
// core count, register address, command codes, status word layout and initiator states.
package core_manage_types;

  localparam int NUM_CPUS = 3;
  localparam int CORE_W   = $clog2(NUM_CPUS);

  localparam logic [31:0] WADDR_MAN = 32'h0000_0040;

  localparam logic [31:0] HALTC0  = 32'h0000_0A00;
  localparam logic [31:0] HALTC1  = 32'h0000_0A01;
  localparam logic [31:0] HALTC2  = 32'h0000_0A02;
  localparam logic [31:0] NHALTC0 = 32'h0000_0B00;
  localparam logic [31:0] NHALTC1 = 32'h0000_0B01;
  localparam logic [31:0] NHALTC2 = 32'h0000_0B02;

  typedef struct packed {
    logic [29:0] rsvd;
    logic        running;
    logic        halt;
  } IO_manage_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT_ACK,
    ST_READ,
    ST_CHECK,
    ST_RESP
  } mgmt_init_state_t;

  function automatic logic [31:0] cmd_word(input logic [CORE_W-1:0] core, input logic halt);
    logic [31:0] w;
    w = '0;
    case (core)
      CORE_W'(0): w = halt ? HALTC0 : NHALTC0;
      CORE_W'(1): w = halt ? HALTC1 : NHALTC1;
      CORE_W'(2): w = halt ? HALTC2 : NHALTC2;
      default:    w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/core_mgmt_initiator_if.sv
// Write/read channels between the core-management initiator and the core-management slave.
interface core_mgmt_initiator_if;
  logic        pwr;
  logic        w_valid;
  logic        awvalid;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        w_done;
  logic        arvalid;
  logic [31:0] raddr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output pwr, w_valid, awvalid, waddr, wdata, arvalid, raddr,
    input  w_done, rvalid, rdata
  );

  modport slave (
    input  pwr, w_valid, awvalid, waddr, wdata, arvalid, raddr,
    output w_done, rvalid, rdata
  );
endinterface

// File: rtl/core_mgmt_initiator.sv
// Turns halt/release requests from the boot core into core-management command writes.
// Define READBACK_EN to add status readback with bounded retries.
module core_mgmt_initiator
  import core_manage_types::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CORE_W-1:0]     req_core,
  input  logic                  req_halt,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  core_mgmt_initiator_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  mgmt_init_state_t  state, state_nxt;
  logic [TO_W-1:0]   tmo_cnt, tmo_nxt, tmo_step;
  logic              err_q, err_nxt;
  logic              pwr_q;
  logic              latch;
  logic              w_fire;
  logic [CORE_W-1:0] core_q;
  logic              halt_q;

  function automatic logic [TO_W-1:0] tmo_inc(input logic [TO_W-1:0] c);
    return (c == TO_W'(TIMEOUT_CYC)) ? c : c + 1'b1;
  endfunction

  assign tmo_step = tmo_inc(tmo_cnt);

`ifdef READBACK_EN
  localparam int RT_W = $clog2(MAX_RETRY + 2);

  logic [RT_W-1:0] rty_cnt, rty_nxt;
  logic            ar_fire;
  logic            rd_ok;
  IO_manage_t      io_st;
  logic            unused_st;

  function automatic logic [RT_W-1:0] rty_inc(input logic [RT_W-1:0] c);
    return (c == {RT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign io_st     = IO_manage_t'(bus.rdata);
  assign unused_st = ^{io_st.rsvd, io_st.running};
`else
  logic unused_rd;
  assign unused_rd = ^{bus.rvalid, bus.rdata, 32'(MAX_RETRY)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
      pwr_q   <= 1'b0;
`ifdef READBACK_EN
      rty_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
      err_q   <= err_nxt;
      pwr_q   <= 1'b1;
`ifdef READBACK_EN
      rty_cnt <= rty_nxt;
`endif
    end
  end

  // Request fields are pure data: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (latch) begin
      core_q <= req_core;
      halt_q <= req_halt;
    end
  end

`ifdef READBACK_EN
  // A missing rvalid in the READ slot is folded into a mismatch.
  always_ff @(posedge clk) begin
    if (ar_fire) begin
      rd_ok <= bus.rvalid && (io_st.halt == halt_q);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    err_nxt   = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    latch     = 1'b0;
    w_fire    = 1'b0;
`ifdef READBACK_EN
    rty_nxt   = rty_cnt;
    ar_fire   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch     = 1'b1;
          tmo_nxt   = '0;
          err_nxt   = (int'(req_core) >= NUM_CPUS);
`ifdef READBACK_EN
          rty_nxt   = '0;
`endif
          state_nxt = ST_WRITE;
        end
      end
      // An illegal core passes through this slot with the bus gated off,
      // giving a fixed two-cycle error response.
      ST_WRITE: begin
        tmo_nxt = '0;
        if (err_q) begin
          state_nxt = ST_RESP;
        end else begin
          w_fire    = 1'b1;
          state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!bus.w_done) begin
`ifdef READBACK_EN
          state_nxt = ST_READ;
`else
          state_nxt = ST_RESP;
`endif
        end else if (tmo_step == TO_W'(TIMEOUT_CYC)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          tmo_nxt = tmo_step;
        end
      end
`ifdef READBACK_EN
      ST_READ: begin
        ar_fire   = 1'b1;
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (rd_ok) begin
          state_nxt = ST_RESP;
        end else begin
          rty_nxt = rty_inc(rty_cnt);
          if (int'(rty_nxt) <= MAX_RETRY) begin
            state_nxt = ST_WRITE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_RESP;
          end
        end
      end
`endif
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rsp_err     = rsp_valid & err_q;
  assign bus.pwr     = pwr_q;
  assign bus.w_valid = w_fire;
  assign bus.awvalid = w_fire;
  assign bus.waddr   = w_fire ? WADDR_MAN : '0;
  assign bus.wdata   = w_fire ? cmd_word(core_q, halt_q) : '0;

`ifdef READBACK_EN
  assign bus.arvalid = ar_fire;
  assign bus.raddr   = ar_fire ? 32'(core_q) : '0;
`else
  assign bus.arvalid = 1'b0;
  assign bus.raddr   = '0;
`endif

endmodule

// File: tb/tb_core_mgmt_initiator.sv
// Directed bench for core_mgmt_initiator with a small behavioural core-management slave.
module tb_core_mgmt_initiator;
  import core_manage_types::*;

  localparam int TMO    = 16;
  localparam int BUDGET = 200;
`ifdef READBACK_EN
  localparam int LAT_OK = 5;
  localparam bit RB     = 1'b1;
`else
  localparam int LAT_OK = 3;
  localparam bit RB     = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_core;
  logic       req_halt;
  logic       rsp_valid;
  logic       rsp_err;

  logic       hold_done;
  logic       bad_rb;
  logic [3:0] slave_halt;

  int n_chk  = 0;
  int n_fail = 0;

  core_mgmt_initiator_if bus ();

  core_mgmt_initiator #(.TIMEOUT_CYC(TMO), .MAX_RETRY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_core  (req_core),
    .req_halt  (req_halt),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Slave: acks each accepted write in the next cycle and tracks per-core halt state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.w_done <= 1'b1;
      slave_halt <= 4'b0010;
    end else begin
      bus.w_done <= hold_done ? 1'b1 : !(bus.w_valid && bus.awvalid && bus.pwr);
      if (bus.w_valid && bus.pwr) begin
        case (bus.wdata)
          HALTC0:  slave_halt[0] <= 1'b1;
          HALTC1:  slave_halt[1] <= 1'b1;
          HALTC2:  slave_halt[2] <= 1'b1;
          NHALTC0: slave_halt[0] <= 1'b0;
          NHALTC1: slave_halt[1] <= 1'b0;
          NHALTC2: slave_halt[2] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign bus.rvalid = bus.arvalid;
  assign bus.rdata  = bus.arvalid ? {30'd0, 1'b1, slave_halt[bus.raddr[1:0]] ^ bad_rb} : 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the response cycle.
  task automatic run_req(input logic [1:0] core, input logic halt, input logic [31:0] exp_wdata,
                         output int lat, output int nw, output bit err, output bit saw_ar);
    lat    = -1;
    nw     = 0;
    err    = 1'b0;
    saw_ar = 1'b0;
    req_core  = core;
    req_halt  = halt;
    req_valid = 1'b1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      if (bus.w_valid) begin
        nw++;
        chk("waddr", bus.waddr, WADDR_MAN);
        chk("wdata", bus.wdata, exp_wdata);
        chk("awvalid", 32'(bus.awvalid), 32'd1);
      end
      if (bus.arvalid) begin
        saw_ar = 1'b1;
        chk("raddr", bus.raddr, 32'(core));
      end
      if (rsp_valid) begin
        lat = cyc;
        err = rsp_err;
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) chk("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, "_w_valid"},   32'(bus.w_valid), 32'd0);
    chk({tag, "_awvalid"},   32'(bus.awvalid), 32'd0);
    chk({tag, "_waddr"},     bus.waddr, 32'd0);
    chk({tag, "_wdata"},     bus.wdata, 32'd0);
    chk({tag, "_arvalid"},   32'(bus.arvalid), 32'd0);
    chk({tag, "_raddr"},     bus.raddr, 32'd0);
  endtask

  initial begin
    int lat;
    int nw;
    bit err;
    bit saw_ar;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_core  = 2'd0;
    req_halt  = 1'b0;
    hold_done = 1'b0;
    bad_rb    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset_pwr", 32'(bus.pwr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("pwr_after_reset", 32'(bus.pwr), 32'd1);

    // 1: release core 1
    run_req(2'd1, 1'b0, NHALTC1, lat, nw, err, saw_ar);
    chk("t1_latency", 32'(lat), 32'(LAT_OK));
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_writes", 32'(nw), 32'd1);
    chk("t1_arvalid_seen", 32'(saw_ar), 32'(RB));
    @(negedge clk);
    chk("t1_slave_halt1", 32'(slave_halt[1]), 32'd0);
    chk("t1_req_ready_back", 32'(req_ready), 32'd1);

    // 2: halt core 0 (readback confirms it when built in)
    run_req(2'd0, 1'b1, HALTC0, lat, nw, err, saw_ar);
    chk("t2_latency", 32'(lat), 32'(LAT_OK));
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_writes", 32'(nw), 32'd1);
    chk("t2_arvalid_seen", 32'(saw_ar), 32'(RB));
    @(negedge clk);
    chk("t2_slave_halt0", 32'(slave_halt[0]), 32'd1);

    // 3: slave never acks -> timeout
    hold_done = 1'b1;
    run_req(2'd2, 1'b1, HALTC2, lat, nw, err, saw_ar);
    chk("t3_latency", 32'(lat), 32'(2 + TMO));
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_writes", 32'(nw), 32'd1);
    chk("t3_arvalid_seen", 32'(saw_ar), 32'd0);
    hold_done = 1'b0;
    @(negedge clk);

    // 4: illegal core index
    run_req(2'd3, 1'b1, 32'd0, lat, nw, err, saw_ar);
    chk("t4_latency", 32'(lat), 32'd2);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_writes", 32'(nw), 32'd0);
    chk("t4_arvalid_seen", 32'(saw_ar), 32'd0);
    @(negedge clk);

`ifdef READBACK_EN
    // 5: status word always disagrees -> three writes then error
    bad_rb = 1'b1;
    run_req(2'd1, 1'b1, HALTC1, lat, nw, err, saw_ar);
    chk("t5_latency", 32'(lat), 32'd13);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_writes", 32'(nw), 32'd3);
    chk("t5_arvalid_seen", 32'(saw_ar), 32'd1);
    bad_rb = 1'b0;
    @(negedge clk);
`endif

    // 6: reset while waiting for the ack
    hold_done = 1'b1;
    req_core  = 2'd2;
    req_halt  = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_write_slot", 32'(bus.w_valid), 32'd1);
    @(negedge clk);
    chk("t6_in_wait", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("t6_abort");
    chk("t6_abort_pwr", 32'(bus.pwr), 32'd0);
    rst       = 1'b0;
    hold_done = 1'b0;
    @(negedge clk);
    chk("t6_pwr_back", 32'(bus.pwr), 32'd1);
    chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    run_req(2'd2, 1'b0, NHALTC2, lat, nw, err, saw_ar);
    chk("t6_latency", 32'(lat), 32'(LAT_OK));
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_writes", 32'(nw), 32'd1);
    @(negedge clk);
    chk("t6_slave_halt2", 32'(slave_halt[2]), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
